// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack handshake carrying one word into an unrelated clock domain.
// ack_in is double-flop synchronized; an optional cycle timeout abandons transfers that are never acknowledged.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_done,
  output logic                  tx_timeout,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_in
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t                state, state_d;
  logic                  ack_meta, ack_sync;
  logic [CW-1:0]         tcnt, tcnt_d;
  logic                  req_d, done_d, to_d;
  logic [DATA_WIDTH-1:0] data_d;

  // A stale ack left over from an abandoned transfer holds off new work until it drops.
  assign tx_ready = (state == IDLE) && !ack_sync;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ack_meta   <= 1'b0;
      ack_sync   <= 1'b0;
      state      <= IDLE;
      tcnt       <= '0;
      req_out    <= 1'b0;
      data_out   <= '0;
      tx_done    <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      ack_meta   <= ack_in;
      ack_sync   <= ack_meta;
      state      <= state_d;
      tcnt       <= tcnt_d;
      req_out    <= req_d;
      data_out   <= data_d;
      tx_done    <= done_d;
      tx_timeout <= to_d;
    end
  end

  always_comb begin
    state_d = state;
    tcnt_d  = tcnt;
    req_d   = req_out;
    data_d  = data_out;
    done_d  = 1'b0;
    to_d    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          data_d  = tx_data;
          req_d   = 1'b1;
          tcnt_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // An ack seen in the same cycle as the timeout wins.
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end else begin
          tcnt_d = tcnt + 1'b1;
          if (TIMEOUT != 0 && tcnt == TMAX) begin
            req_d   = 1'b0;
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RELEASE: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: instance a (TIMEOUT=64) for transfers, instance b (TIMEOUT=4)
// for timeout, stale-ack and mid-transfer reset; completion pulses are checked against a scoreboard.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] a_data, b_data, a_dout, b_dout;
  logic       a_valid, b_valid, a_ready, b_ready, a_done, b_done, a_to, b_to;
  logic       a_req, b_req, a_ack, b_ack;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    bit         inst;
    bit         is_to;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT(64)) u_a (
    .clk(clk), .n_rst(n_rst), .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready),
    .tx_done(a_done), .tx_timeout(a_to), .req_out(a_req), .data_out(a_dout), .ack_in(a_ack));

  cdc_handshake_tx #(.DATA_WIDTH(8), .TIMEOUT(4)) u_b (
    .clk(clk), .n_rst(n_rst), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
    .tx_done(b_done), .tx_timeout(b_to), .req_out(b_req), .data_out(b_dout), .ack_in(b_ack));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon(input bit inst, input bit is_to, input logic [7:0] d,
                     input logic req, input logic rdy);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_unexpected: inst %0d pulse timeout=%0d with nothing expected", inst, is_to);
    end else begin
      e = sb.pop_front();
      chk("sb_inst", 32'(inst), 32'(e.inst));
      chk("sb_kind", 32'(is_to), 32'(e.is_to));
      chk("sb_data", 32'(d), 32'(e.data));
      chk("sb_req_low", 32'(req), 32'd0);
      chk("sb_ready", 32'(rdy), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (a_done || a_to) mon(1'b0, a_to, a_dout, a_req, a_ready);
      if (b_done || b_to) mon(1'b1, b_to, b_dout, b_req, b_ready);
    end
  end

  initial begin
    n_rst = 1'b0;
    a_data = '0; b_data = '0; a_valid = 1'b0; b_valid = 1'b0; a_ack = 1'b0; b_ack = 1'b0;

    // reset values, during and after reset
    #2;
    chk("rst_a_ready", 32'(a_ready), 32'd1);
    chk("rst_a_req", 32'(a_req), 32'd0);
    chk("rst_a_data", 32'(a_dout), 32'd0);
    chk("rst_a_done", 32'(a_done), 32'd0);
    chk("rst_a_to", 32'(a_to), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd1);
    repeat (2) tick();
    n_rst = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(a_ready), 32'd1);
    chk("post_rst_a_req", 32'(a_req), 32'd0);

    // basic transfer 0xA5: ack rises 3 cycles after req, falls 4 cycles later
    tick();
    a_valid = 1'b1; a_data = 8'hA5;
    sb.push_back('{inst: 1'b0, is_to: 1'b0, data: 8'hA5});
    @(negedge clk);
    chk("basic_ready_pre", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0; a_data = 8'h00;
    for (int i = 0; i <= 12; i++) begin
      if (i == 3) a_ack = 1'b1;
      if (i == 7) a_ack = 1'b0;
      @(negedge clk);
      chk($sformatf("basic_req[%0d]", i), 32'(a_req), 32'(i < 6));
      chk($sformatf("basic_data[%0d]", i), 32'(a_dout), 32'hA5);
      chk($sformatf("basic_done[%0d]", i), 32'(a_done), 32'(i == 10));
      chk($sformatf("basic_ready[%0d]", i), 32'(a_ready), 32'(i >= 10));
      chk($sformatf("basic_to[%0d]", i), 32'(a_to), 32'd0);
      tick();
    end

    // back-to-back 0x01 then 0x02, valid held high
    a_valid = 1'b1; a_data = 8'h01;
    sb.push_back('{inst: 1'b0, is_to: 1'b0, data: 8'h01});
    sb.push_back('{inst: 1'b0, is_to: 1'b0, data: 8'h02});
    tick();
    a_data = 8'h02;
    for (int i = 0; i <= 14; i++) begin
      if (i == 0 || i == 8) a_ack = 1'b1;
      if (i == 4 || i == 10) a_ack = 1'b0;
      if (i == 8) a_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_req[%0d]", i), 32'(a_req), 32'((i < 3) || (i >= 8 && i < 11)));
      chk($sformatf("b2b_data[%0d]", i), 32'(a_dout), (i < 8) ? 32'h01 : 32'h02);
      chk($sformatf("b2b_done[%0d]", i), 32'(a_done), 32'(i == 7 || i == 13));
      chk($sformatf("b2b_ready[%0d]", i), 32'(a_ready), 32'(i == 7 || i >= 13));
      tick();
    end

    // timeout on b (TIMEOUT=4), ack held low
    b_valid = 1'b1; b_data = 8'h3C;
    sb.push_back('{inst: 1'b1, is_to: 1'b1, data: 8'h3C});
    tick();
    b_valid = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("to_req[%0d]", i), 32'(b_req), 32'(i < 4));
      chk($sformatf("to_pulse[%0d]", i), 32'(b_to), 32'(i == 4));
      chk($sformatf("to_ready[%0d]", i), 32'(b_ready), 32'(i >= 4));
      chk($sformatf("to_done[%0d]", i), 32'(b_done), 32'd0);
      tick();
    end

    // stale ack: ack high 5 cycles; valid raised while ready is blocked
    for (int j = 0; j <= 9; j++) begin
      if (j == 0) b_ack = 1'b1;
      if (j == 2) begin b_valid = 1'b1; b_data = 8'h5A; end
      if (j == 5) b_ack = 1'b0;
      if (j == 8) b_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("stale_ready[%0d]", j), 32'(b_ready), 32'(j < 2 || j == 7));
      chk($sformatf("stale_req[%0d]", j), 32'(b_req), 32'(j >= 8));
      chk($sformatf("stale_data[%0d]", j), 32'(b_dout), (j < 8) ? 32'h3C : 32'h5A);
      if (j < 9) tick();
    end

    // reset in the middle of REQ on b
    #2;
    n_rst = 1'b0;
    #1;
    chk("midrst_req", 32'(b_req), 32'd0);
    chk("midrst_data", 32'(b_dout), 32'd0);
    chk("midrst_ready", 32'(b_ready), 32'd1);
    chk("midrst_a_data", 32'(a_dout), 32'd0);
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("after_rst_ready[%0d]", i), 32'(b_ready), 32'd1);
      chk($sformatf("after_rst_req[%0d]", i), 32'(b_req), 32'd0);
      chk($sformatf("after_rst_to[%0d]", i), 32'(b_to), 32'd0);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side transmitter for a four-phase req/ack handshake that carries a data word from the `clk` domain to a receiver in an unrelated clock domain. The block accepts a word via a local valid/ready interface and holds it stable on `data_out`. It then drives `req_out` and double-flop synchronizes the receiver's asynchronous `ack_in` before acting on it. A cycle timeout abandons a transfer when the far side never acknowledges.

## Interface
- `DATA_WIDTH`, default 8: width of the transferred word.
- `TIMEOUT`, default 64: cycles `req_out` may stay high without a synchronized ack. 0 disables the timeout.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `tx_data`  in  DATA_WIDTH  word to send; sampled on accept.
- `tx_valid`  in  1  local request to send `tx_data`.
- `tx_ready`  out  1  block can accept a word this cycle (combinational).
- `tx_done`  out  1  one-cycle pulse when a handshake completes.
- `tx_timeout`  out  1  one-cycle pulse when a transfer is abandoned.
- `req_out`  out  1  handshake request to the remote domain; registered.
- `data_out`  out  DATA_WIDTH  word presented to the remote domain; registered.
- `ack_in`  in  1  remote acknowledge, asynchronous to `clk`.

## Operation
- Synchronizer: `ack_in` → `ack_meta` → `ack_sync`, two flops, both reset to 0. No logic uses `ack_in` or `ack_meta` directly.
- Counter `tcnt`, width clog2(TIMEOUT+1) (min 1):
  - cleared on entry to REQ;
  - increments each REQ cycle while `ack_sync`=0.
- `tx_ready` = (state==IDLE) && !`ack_sync`. A stale ack from an abandoned transfer blocks new transfers until it drops.
- FSM states:
  - IDLE: on `tx_valid && tx_ready`, set `data_out`←`tx_data` and `req_out`←1, clear `tcnt`, go to REQ.
  - REQ: if `ack_sync`=1, set `req_out`←0 and go to RELEASE. Otherwise, if TIMEOUT≠0 and `tcnt`==TIMEOUT-1, set `req_out`←0, pulse `tx_timeout`, and go to IDLE.
  - RELEASE: wait for `ack_sync`=0. Then pulse `tx_done` and go to IDLE.
- `ack_sync`=1 in REQ takes priority over a timeout in the same cycle.
- `data_out` changes only on accept. It holds its value through REQ and RELEASE and keeps the last value afterwards.
- `tx_valid` outside IDLE, or with `ack_sync`=1, is ignored. Nothing is queued.

## Timing
- Reset values:
  - state IDLE;
  - `req_out`=0, `data_out`=0, `tx_done`=0, `tx_timeout`=0;
  - `ack_meta`=`ack_sync`=0, `tcnt`=0.
  - `tx_ready`=1 during and after reset.
- Accept at edge N: `req_out` and `data_out` are valid after edge N. `data_out` is stable at least one cycle before `req_out` can be sampled high remotely, because both come from the same edge and the receiver synchronizes `req_out`.
- Ack propagation:
  - `ack_in` rising before edge M gives `ack_sync`=1 after edge M+1.
  - `req_out` falls after edge M+2.
- Ack release:
  - `ack_in` falling before edge K gives `ack_sync`=0 after edge K+1.
  - `tx_done` is high for the cycle after edge K+2, with state IDLE.
  - `tx_ready` is 1 in that same cycle.
- Back-to-back: a new accept is allowed in the `tx_done` cycle.
- Timeout: `req_out` is high for exactly TIMEOUT cycles. `tx_timeout` is high in the cycle after `req_out` falls.
- Mid-transfer reset: all outputs return to reset values asynchronously. An in-flight word is lost and the remote side sees `req_out` drop.

## Test plan
- Reset with `ack_in`=0: all outputs 0 and `tx_ready`=1.
- Basic transfer, DATA_WIDTH=8:
  - stimulus: send 0xA5; `ack_in` rises 3 cycles after `req_out`, falls 4 cycles later;
  - required: `data_out`=0xA5 from accept until return to IDLE; `req_out` falls 2 cycles after `ack_in` rises; one `tx_done` pulse 2 cycles after `ack_in` falls; no `tx_timeout`.
- Back-to-back:
  - stimulus: `tx_valid` held high with words 0x01 then 0x02;
  - required: second accept in the `tx_done` cycle; `data_out` steps 0x01→0x02 only at that accept.
- Timeout, TIMEOUT=4, `ack_in` held 0:
  - `req_out` high for 4 cycles;
  - then `tx_timeout` pulses for one cycle;
  - `tx_ready`=1 and `tx_done` never pulses.
- Stale ack:
  - stimulus: after the timeout, raise `ack_in` for 5 cycles while `tx_valid`=1;
  - required: `tx_ready`=0 from 2 cycles after the rise until 2 cycles after the fall; no accept in that window; accept resumes afterward.
- Reset mid-REQ:
  - stimulus: assert `n_rst`=0 while `req_out`=1;
  - required: `req_out` and `data_out` go to 0 immediately; after release the FSM is in IDLE and `tx_ready`=1.
